insn_queue: RTL and testbench
=============================

// Module: insn_queue
//
// PURPOSE
//  Decoupling FIFO between the instruction prefetch and the decode stage.
//  Absorbs bus-latency jitter and decode stalls so prefetch keeps fetching.
//  Carries {illegal, pc, insn} per entry. Flushed on any branch or cache clear.
//  Stops accepting words after a bus-error word until the next flush.
//
// PARAMETERS
//  ADDRESS_WIDTH  30  width of the PC fields (AW)
//  INSN_WIDTH     32  instruction word width (IW)
//  LGDEPTH        3   log2 of queue depth; depth = 2**LGDEPTH, LGDEPTH >= 1
//
// PORTS
//  i_clk          in   1        system clock, all logic on rising edge
//  i_reset_n      in   1        synchronous reset, active low
//  i_new_pc       in   1        CPU branch request; flushes the queue
//  i_clear_cache  in   1        CPU cache clear; flushes the queue
//  i_pf_valid     in   1        prefetch word valid
//  i_pf_illegal   in   1        prefetch word came from a bus error
//  i_pf_insn      in   IW       prefetch instruction word
//  i_pf_pc        in   AW       PC of the prefetch word
//  o_pf_ready     out  1        queue accepts a word this cycle
//  o_valid        out  1        head entry valid for decode
//  o_illegal      out  1        head entry is a bus-error entry
//  o_insn         out  IW       head instruction word
//  o_pc           out  AW       head PC
//  i_ready        in   1        decode consumes head this cycle
//  o_count        out  LGDEPTH+1  entries held, including the head
//
// BEHAVIOUR
//  - Reset (i_reset_n==0 at a clock edge):
//    - o_valid=0, o_illegal=0, o_insn=0, o_pc=0, o_count=0, o_pf_ready=1.
//    - Pointers are zeroed; halted flag is cleared.
//  - flush = i_new_pc | i_clear_cache.
//    - Next cycle: same state as reset.
//    - Any push or pop in the flush cycle is discarded.
//  - push = i_pf_valid & o_pf_ready & !flush.
//  - pop  = o_valid & i_ready & !flush.
//  - o_pf_ready is registered:
//    - o_pf_ready = !halted & (next_count < 2**LGDEPTH).
//    - When full, no push occurs, even if a pop happens in the same cycle.
//    - o_pf_ready rises the cycle after the pop.
//  - Halted flag:
//    - Set on a push with i_pf_illegal=1.
//    - Cleared only by reset or flush.
//    - Entries already queued still drain normally.
//  - Storage is circular: wr_ptr and rd_ptr are LGDEPTH+1 bits and wrap modulo 2**(LGDEPTH+1).
//    - full  = (ptr MSBs differ) & (low bits equal).
//    - empty = ptrs equal.
//  - Output stage is registered first-word-fall-through:
//    - A push into an empty queue gives o_valid=1 on the next edge.
//    - Latency is 1 cycle.
//    - On pop with more entries, the next entry appears on the following edge with no bubble.
//    - On pop of the last entry, o_valid=0.
//    - A simultaneous push into a one-entry queue with pop presents the new word the next cycle.
//  - o_insn, o_pc and o_illegal hold their values while o_valid & !i_ready.
//  - o_count:
//    - +1 on push only, -1 on pop only, unchanged on both.
//    - Never exceeds 2**LGDEPTH.
//  - Mid-operation reset or flush discards everything, including the head.
//
// CONFIGURATION
//  INSN_QUEUE_BYPASS_EN
//  - Defined:
//    - When the queue is empty and no flush is active, o_valid/o_insn/o_pc/o_illegal
//      are driven combinationally from the i_pf_* inputs.
//    - Such a word is popped by i_ready without being written, giving zero latency.
//    - If not consumed, it is written and held as normal.
//  - Not defined:
//    - Outputs are purely registered, with 1-cycle latency.
//    - There is no combinational path from i_pf_* to o_*.
//
// TESTING
//  1. Reset then push A (pc 0x100), i_ready=1 -> o_valid=1, o_pc=0x100 one cycle later
//     (same cycle with BYPASS_EN); o_count returns to 0.
//  2. i_ready=0, push 8 words (LGDEPTH=3) -> o_count=8, o_pf_ready=0;
//     a 9th i_pf_valid is not taken; one pop -> o_pf_ready=1 next cycle.
//  3. Full queue, i_ready=1 for 8 cycles -> words emerge in order, no bubbles,
//     o_valid=0 after the last one.
//  4. 5 entries held, assert i_new_pc with i_pf_valid=1 -> next cycle o_valid=0,
//     o_count=0, the flush-cycle word is absent.
//  5. Push W1, then illegal W2, then W3 offered -> W3 refused (o_pf_ready=0);
//     W1 then W2 emerge with o_illegal=0 then 1; after i_clear_cache, o_pf_ready=1.
//  6. i_reset_n=0 mid-stream with 3 entries -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/insn_queue_if.sv
// Handshake bundle between prefetch, the instruction queue and decode.
// The queue uses the slave modport; the prefetch/decode side uses master.
interface insn_queue_if #(
    parameter int ADDRESS_WIDTH = 30,
    parameter int INSN_WIDTH    = 32,
    parameter int LGDEPTH       = 3
);
    logic                     i_new_pc;
    logic                     i_clear_cache;
    logic                     i_pf_valid;
    logic                     i_pf_illegal;
    logic [INSN_WIDTH-1:0]    i_pf_insn;
    logic [ADDRESS_WIDTH-1:0] i_pf_pc;
    logic                     o_pf_ready;
    logic                     o_valid;
    logic                     o_illegal;
    logic [INSN_WIDTH-1:0]    o_insn;
    logic [ADDRESS_WIDTH-1:0] o_pc;
    logic                     i_ready;
    logic [LGDEPTH:0]         o_count;

    modport slave (
        input  i_new_pc, i_clear_cache, i_pf_valid, i_pf_illegal, i_pf_insn, i_pf_pc, i_ready,
        output o_pf_ready, o_valid, o_illegal, o_insn, o_pc, o_count
    );

    modport master (
        output i_new_pc, i_clear_cache, i_pf_valid, i_pf_illegal, i_pf_insn, i_pf_pc, i_ready,
        input  o_pf_ready, o_valid, o_illegal, o_insn, o_pc, o_count
    );
endinterface

// File: rtl/insn_queue.sv
// Prefetch-to-decode instruction FIFO with registered first-word-fall-through head.
// Optional macro INSN_QUEUE_BYPASS_EN adds a zero-latency path when the queue is empty.
module insn_queue #(
    parameter int ADDRESS_WIDTH = 30,
    parameter int INSN_WIDTH    = 32,
    parameter int LGDEPTH       = 3
) (
    input  logic      i_clk,
    input  logic      i_reset_n,
    insn_queue_if.slave q
);
    localparam int PW = LGDEPTH + 1;
    localparam int EW = 1 + ADDRESS_WIDTH + INSN_WIDTH;
    localparam int DEPTH = 1 << LGDEPTH;

    logic [EW-1:0] mem [DEPTH];
    logic [EW-1:0] ram_rdata;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_q, count_d;
    logic          halted_q, halted_d, ready_q, ready_d, valid_q, valid_d;
    logic          head_sel_q, head_sel_d, head_zero_q, head_zero_d;
    logic [EW-1:0] byp_word_q, byp_word_d;

    logic          flush, push, pop, full_d, fwd, ram_load;
    logic          out_valid;
    logic [EW-1:0] pf_word, stored_word, out_word;

    assign pf_word     = {q.i_pf_illegal, q.i_pf_pc, q.i_pf_insn};
    // Head comes from the RAM read register, or from a word forwarded in the
    // cycle it was written into an empty queue (RAM not yet readable there).
    assign stored_word = head_zero_q ? '0 : (head_sel_q ? byp_word_q : ram_rdata);

`ifdef INSN_QUEUE_BYPASS_EN
    logic bypass;
    assign bypass    = !valid_q && !flush && q.i_pf_valid && ready_q;
    assign out_valid = valid_q | bypass;
    assign out_word  = bypass ? pf_word : stored_word;
`else
    assign out_valid = valid_q;
    assign out_word  = stored_word;
`endif

    assign q.o_valid    = out_valid;
    assign {q.o_illegal, q.o_pc, q.o_insn} = out_word;
    assign q.o_pf_ready = ready_q;
    assign q.o_count    = count_q;

    always_comb begin
        flush    = q.i_new_pc | q.i_clear_cache;
        push     = q.i_pf_valid & ready_q & ~flush;
        pop      = out_valid & q.i_ready & ~flush;
        wr_ptr_d = flush ? '0 : wr_ptr_q + PW'(push);
        rd_ptr_d = flush ? '0 : rd_ptr_q + PW'(pop);
        count_d  = flush ? '0 : count_q + PW'(push) - PW'(pop);
        halted_d = ~flush & (halted_q | (push & q.i_pf_illegal));
        full_d   = (wr_ptr_d[LGDEPTH] != rd_ptr_d[LGDEPTH]) &&
                   (wr_ptr_d[LGDEPTH-1:0] == rd_ptr_d[LGDEPTH-1:0]);
        ready_d  = ~halted_d & ~full_d;
        valid_d  = (wr_ptr_d != rd_ptr_d);
        // The new head is the word being written right now only if the queue drains to it.
        fwd         = push & (wr_ptr_q == rd_ptr_d);
        ram_load    = valid_d & ~fwd;
        head_sel_d  = valid_d ? fwd : head_sel_q;
        head_zero_d = flush | (head_zero_q & ~valid_d);
        byp_word_d  = fwd ? pf_word : byp_word_q;
    end

    always_ff @(posedge i_clk) begin
        if (push)
            mem[wr_ptr_q[LGDEPTH-1:0]] <= pf_word;
        if (ram_load)
            ram_rdata <= mem[rd_ptr_d[LGDEPTH-1:0]];
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            halted_q    <= 1'b0;
            ready_q     <= 1'b1;
            valid_q     <= 1'b0;
            head_sel_q  <= 1'b0;
            head_zero_q <= 1'b1;
            byp_word_q  <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            halted_q    <= halted_d;
            ready_q     <= ready_d;
            valid_q     <= valid_d;
            head_sel_q  <= head_sel_d;
            head_zero_q <= head_zero_d;
            byp_word_q  <= byp_word_d;
        end
    end
endmodule

// File: tb/tb_insn_queue.sv
// Self-checking bench for insn_queue: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_insn_queue;
    localparam int AW = 30;
    localparam int IW = 32;
    localparam int LG = 3;
    localparam int DEPTH = 8;

    typedef struct packed {
        logic          ill;
        logic [AW-1:0] pc;
        logic [IW-1:0] insn;
    } ent_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    insn_queue_if #(.ADDRESS_WIDTH(AW), .INSN_WIDTH(IW), .LGDEPTH(LG)) bus ();
    insn_queue #(.ADDRESS_WIDTH(AW), .INSN_WIDTH(IW), .LGDEPTH(LG)) dut (
        .i_clk(clk), .i_reset_n(rst_n), .q(bus.slave)
    );

    ent_t mq[$];
    bit   m_ready = 1'b1;
    bit   m_halted = 1'b0;
    bit   m_zero = 1'b1;
    int   checks = 0;
    int   failures = 0;

    task automatic drive(input bit v, input bit ill, input logic [AW-1:0] pc,
                         input logic [IW-1:0] insn, input bit rdy, input bit np, input bit cc);
        bus.i_pf_valid    = v;
        bus.i_pf_illegal  = ill;
        bus.i_pf_pc       = pc;
        bus.i_pf_insn     = insn;
        bus.i_ready       = rdy;
        bus.i_new_pc      = np;
        bus.i_clear_cache = cc;
    endtask

    // Advance the reference model by one clock using the current inputs, then clock the DUT.
    task automatic step();
        bit   fl;
        bit   push;
        bit   pop;
        ent_t e;
        fl   = bus.i_new_pc | bus.i_clear_cache;
        push = bus.i_pf_valid & m_ready & !fl;
        pop  = (mq.size() != 0) & bus.i_ready & !fl;
        if (!rst_n || fl) begin
            mq.delete();
            m_halted = 1'b0;
            m_zero   = 1'b1;
        end else begin
            if (pop) begin
                $display("pop  pc=%h insn=%h illegal=%0d", mq[0].pc, mq[0].insn, mq[0].ill);
                void'(mq.pop_front());
            end
            if (push) begin
                e.ill  = bus.i_pf_illegal;
                e.pc   = bus.i_pf_pc;
                e.insn = bus.i_pf_insn;
                mq.push_back(e);
                m_zero = 1'b0;
                if (e.ill) m_halted = 1'b1;
            end
        end
        m_ready = !m_halted && (mq.size() < DEPTH);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        checks++;
        if (bus.o_valid !== 1'b0 || bus.o_count !== 4'd0 || bus.o_pf_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ctrl: valid=%b count=%0d ready=%b, need 0/0/1",
                     bus.o_valid, bus.o_count, bus.o_pf_ready);
        end
        checks++;
        if ({bus.o_illegal, bus.o_pc, bus.o_insn} !== '0) begin
            failures++;
            $display("FAIL reset_data: ill=%b pc=%h insn=%h, need zeros",
                     bus.o_illegal, bus.o_pc, bus.o_insn);
        end
    endtask

    task automatic test_single();
        drive(1'b1, 1'b0, 30'h100, 32'hA0A0_0001, 1'b1, 1'b0, 1'b0);
        step();
        checks++;
        if (bus.o_valid !== 1'b1 || bus.o_pc !== 30'h100 || bus.o_count !== 4'd1) begin
            failures++;
            $display("FAIL single_latency: valid=%b pc=%h count=%0d, need 1/100/1",
                     bus.o_valid, bus.o_pc, bus.o_count);
        end
        drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        step();
        checks++;
        if (bus.o_valid !== 1'b0 || bus.o_count !== 4'd0) begin
            failures++;
            $display("FAIL single_drain: valid=%b count=%0d, need 0/0", bus.o_valid, bus.o_count);
        end
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 1'b0, AW'($urandom()), $urandom(), 1'b0, 1'b0, 1'b0);
            step();
        end
        checks++;
        if (bus.o_count !== 4'd8 || bus.o_pf_ready !== 1'b0) begin
            failures++;
            $display("FAIL full: count=%0d ready=%b, need 8/0", bus.o_count, bus.o_pf_ready);
        end
        drive(1'b1, 1'b0, 30'h3FF, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
        step();
        checks++;
        if (bus.o_count !== 4'd8) begin
            failures++;
            $display("FAIL ninth_refused: count=%0d, need 8", bus.o_count);
        end
        // Pop with a word still offered: full queue must not take it this cycle.
        drive(1'b1, 1'b0, 30'h3FF, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0);
        step();
        checks++;
        if (bus.o_count !== 4'd7 || bus.o_pf_ready !== 1'b1) begin
            failures++;
            $display("FAIL pop_from_full: count=%0d ready=%b, need 7/1", bus.o_count, bus.o_pf_ready);
        end
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (bus.o_valid !== 1'b1 || {bus.o_illegal, bus.o_pc, bus.o_insn} !== mq[0]) begin
                failures++;
                $display("FAIL drain_order[%0d]: valid=%b pc=%h insn=%h, need 1 pc=%h insn=%h",
                         i, bus.o_valid, bus.o_pc, bus.o_insn, mq[0].pc, mq[0].insn);
            end
            drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
            step();
        end
        checks++;
        if (bus.o_valid !== 1'b0 || bus.o_count !== 4'd0) begin
            failures++;
            $display("FAIL drain_empty: valid=%b count=%0d, need 0/0", bus.o_valid, bus.o_count);
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, AW'(32'h200 + i), $urandom(), 1'b0, 1'b0, 1'b0);
            step();
        end
        drive(1'b1, 1'b0, 30'h777, 32'h1234_5678, 1'b1, 1'b1, 1'b0);
        step();
        checks++;
        if (bus.o_valid !== 1'b0 || bus.o_count !== 4'd0 || bus.o_pf_ready !== 1'b1 ||
            bus.o_pc !== '0) begin
            failures++;
            $display("FAIL flush: valid=%b count=%0d ready=%b pc=%h, need 0/0/1/0",
                     bus.o_valid, bus.o_count, bus.o_pf_ready, bus.o_pc);
        end
        drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        step();
        checks++;
        if (bus.o_valid !== 1'b0 || bus.o_count !== 4'd0) begin
            failures++;
            $display("FAIL flush_word_absent: valid=%b count=%0d, need 0/0", bus.o_valid, bus.o_count);
        end
    endtask

    task automatic test_halt();
        drive(1'b1, 1'b0, 30'h10, 32'h1111_1111, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b1, 1'b1, 30'h14, 32'h2222_2222, 1'b0, 1'b0, 1'b0);
        step();
        checks++;
        if (bus.o_pf_ready !== 1'b0) begin
            failures++;
            $display("FAIL halt_ready: ready=%b, need 0", bus.o_pf_ready);
        end
        drive(1'b1, 1'b0, 30'h18, 32'h3333_3333, 1'b1, 1'b0, 1'b0);
        checks++;
        if (bus.o_illegal !== 1'b0 || bus.o_pc !== 30'h10) begin
            failures++;
            $display("FAIL halt_w1: ill=%b pc=%h, need 0/10", bus.o_illegal, bus.o_pc);
        end
        step();
        checks++;
        if (bus.o_valid !== 1'b1 || bus.o_illegal !== 1'b1 || bus.o_pc !== 30'h14) begin
            failures++;
            $display("FAIL halt_w2: valid=%b ill=%b pc=%h, need 1/1/14",
                     bus.o_valid, bus.o_illegal, bus.o_pc);
        end
        step();
        checks++;
        if (bus.o_valid !== 1'b0 || bus.o_count !== 4'd0 || bus.o_pf_ready !== 1'b0) begin
            failures++;
            $display("FAIL halt_w3_refused: valid=%b count=%0d ready=%b, need 0/0/0",
                     bus.o_valid, bus.o_count, bus.o_pf_ready);
        end
        drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        step();
        checks++;
        if (bus.o_pf_ready !== 1'b1) begin
            failures++;
            $display("FAIL halt_clear: ready=%b, need 1", bus.o_pf_ready);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, AW'(32'h300 + i), $urandom(), 1'b0, 1'b0, 1'b0);
            step();
        end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        checks++;
        if (bus.o_valid !== 1'b0 || bus.o_count !== 4'd0 || bus.o_pf_ready !== 1'b1 ||
            {bus.o_illegal, bus.o_pc, bus.o_insn} !== '0) begin
            failures++;
            $display("FAIL reset_mid: valid=%b count=%0d ready=%b pc=%h, need 0/0/1/0",
                     bus.o_valid, bus.o_count, bus.o_pf_ready, bus.o_pc);
        end
    endtask

    task automatic test_random();
        int bad;
        for (int c = 0; c < 600; c++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, AW'($urandom()),
                  $urandom(), $urandom_range(0, 2) != 0, $urandom_range(0, 31) == 0,
                  $urandom_range(0, 63) == 0);
            rst_n = ($urandom_range(0, 99) != 0);
            step();
            rst_n = 1'b1;
            bad = 0;
            checks++;
            if (bus.o_valid !== (mq.size() != 0) || bus.o_count !== 4'(mq.size()) ||
                bus.o_pf_ready !== m_ready) begin
                failures++;
                bad = 1;
                $display("FAIL rand_ctrl@%0d: valid=%b count=%0d ready=%b, need %b/%0d/%b",
                         c, bus.o_valid, bus.o_count, bus.o_pf_ready,
                         mq.size() != 0, mq.size(), m_ready);
            end
            if (mq.size() != 0 && bad == 0) begin
                checks++;
                if ({bus.o_illegal, bus.o_pc, bus.o_insn} !== mq[0]) begin
                    failures++;
                    $display("FAIL rand_head@%0d: ill=%b pc=%h insn=%h, need %b/%h/%h", c,
                             bus.o_illegal, bus.o_pc, bus.o_insn, mq[0].ill, mq[0].pc, mq[0].insn);
                end
            end else if (m_zero) begin
                checks++;
                if ({bus.o_illegal, bus.o_pc, bus.o_insn} !== '0) begin
                    failures++;
                    $display("FAIL rand_zero@%0d: ill=%b pc=%h insn=%h, need zeros", c,
                             bus.o_illegal, bus.o_pc, bus.o_insn);
                end
            end
        end
    endtask

    initial begin
        drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        test_reset();
        test_single();
        test_fill_drain();
        test_flush();
        test_halt();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
